// File: rtl/demux_buffer.sv
// Routes each accepted input word into one of two independent 2-entry FIFOs, chosen by select.
// Optional per-channel push counters cnt1/cnt2 are present when DEMUX_BUFFER_STATS_EN is defined.
module demux_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out2,
    output logic             out2_valid,
    input  logic             out2_ready
`ifdef DEMUX_BUFFER_STATS_EN
    ,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Index 0 is channel 1 (select=0), index 1 is channel 2 (select=1).
    logic [1:0][1:0]       state_r;
    logic [1:0][WIDTH-1:0] head_r;
    logic [1:0][WIDTH-1:0] tail_r;
    logic [1:0]            push_s;
    logic [1:0]            pop_s;
    logic [1:0]            ready_s;

    // Handshake decode; in_ready looks only at the chosen channel's fill state.
    always_comb begin
        ready_s = {out2_ready, out_ready};
        if (!rst_n) begin
            in_ready = 1'b1;
        end else if (select) begin
            in_ready = (state_r[1] != ST_FULL);
        end else begin
            in_ready = (state_r[0] != ST_FULL);
        end
        push_s[0] = in_valid && in_ready && !select;
        push_s[1] = in_valid && in_ready && select;
        pop_s[0]  = (state_r[0] != ST_EMPTY) && ready_s[0];
        pop_s[1]  = (state_r[1] != ST_EMPTY) && ready_s[1];
    end

    // Per-channel FIFO state and storage; the head register feeds the output directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                case (state_r[c])
                    ST_EMPTY: begin
                        if (push_s[c]) begin
                            head_r[c]  <= data;
                            state_r[c] <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (push_s[c] && pop_s[c]) begin
                            head_r[c] <= data;
                        end else if (push_s[c]) begin
                            tail_r[c]  <= data;
                            state_r[c] <= ST_FULL;
                        end else if (pop_s[c]) begin
                            state_r[c] <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        // A push cannot land here: in_ready is low for a full channel.
                        if (pop_s[c]) begin
                            head_r[c]  <= tail_r[c];
                            state_r[c] <= ST_ONE;
                        end
                    end
                    default: begin
                        state_r[c] <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    assign out        = head_r[0];
    assign out2       = head_r[1];
    assign out_valid  = (state_r[0] != ST_EMPTY);
    assign out2_valid = (state_r[1] != ST_EMPTY);

`ifdef DEMUX_BUFFER_STATS_EN
    logic [7:0] cnt1_r;
    logic [7:0] cnt2_r;

    // Accepted-push counters, wrapping modulo 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1_r <= 8'd0;
            cnt2_r <= 8'd0;
        end else begin
            if (push_s[0]) begin
                cnt1_r <= cnt1_r + 8'd1;
            end
            if (push_s[1]) begin
                cnt2_r <= cnt2_r + 8'd1;
            end
        end
    end

    assign cnt1 = cnt1_r;
    assign cnt2 = cnt2_r;
`endif

endmodule

// File: tb/tb_demux_buffer.sv
// Directed, table-driven bench for demux_buffer plus hand-written reset and counter sequences.
module tb_demux_buffer;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       select;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out2;
    logic       out2_valid;
    logic       out2_ready;
`ifdef DEMUX_BUFFER_STATS_EN
    logic [7:0] cnt1;
    logic [7:0] cnt2;
`endif

    int n_checks;
    int n_fail;

    demux_buffer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .select     (select),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out2       (out2),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready)
`ifdef DEMUX_BUFFER_STATS_EN
        ,
        .cnt1       (cnt1),
        .cnt2       (cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sel;
        logic       iv;
        logic       ordy;
        logic       o2rdy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_out;
        logic       e_o2v;
        logic [7:0] e_out2;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic s, input logic iv, input logic r1, input logic r2);
        data       = d;
        select     = s;
        in_valid   = iv;
        out_ready  = r1;
        out2_ready = r2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Expected outputs in each row describe the state left by the rows before it.
        //          data   sel   iv    ordy  o2rdy ir    ov    out    o2v   out2
        vecs[0]  = '{8'hAE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAE, 1'b0, 8'h00};
        vecs[2]  = '{8'hAE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAE, 1'b0, 8'h00};
        vecs[3]  = '{8'hF9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAE, 1'b1, 8'hAE};
        vecs[4]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAE, 1'b1, 8'hAE};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAE, 1'b1, 8'hAE};
        vecs[6]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAE, 1'b1, 8'hAE};
        vecs[7]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAE, 1'b1, 8'hF9};
        vecs[8]  = '{8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAE, 1'b0, 8'h00};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
        vecs[10] = '{8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
        vecs[11] = '{8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00};
        vecs[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[14] = '{8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[15] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h44};
        vecs[16] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 8'h44};
        vecs[17] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};

        // Reset values while rst_n is held low.
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out2_valid", {31'd0, out2_valid}, 32'd0);
        check("reset out", {24'd0, out}, 32'd0);
        check("reset out2", {24'd0, out2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].data, vecs[i].sel, vecs[i].iv, vecs[i].ordy, vecs[i].o2rdy);
            #1;
            check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
            check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("vec%0d out2_valid", i), {31'd0, out2_valid}, {31'd0, vecs[i].e_o2v});
            if (vecs[i].e_ov) check($sformatf("vec%0d out", i), {24'd0, out}, {24'd0, vecs[i].e_out});
            if (vecs[i].e_o2v) check($sformatf("vec%0d out2", i), {24'd0, out2}, {24'd0, vecs[i].e_out2});
        end

        // Fill both channels, then pulse reset between clock edges.
        @(negedge clk); drive(8'hA1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(8'hA2, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(8'hB1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(8'hB2, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("full ch2 in_ready", {31'd0, in_ready}, 32'd0);
        check("full out", {24'd0, out}, 32'hA1);
        check("full out2", {24'd0, out2}, 32'hB1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {31'd0, out_valid}, 32'd0);
        check("async rst out2_valid", {31'd0, out2_valid}, 32'd0);
        check("async rst in_ready", {31'd0, in_ready}, 32'd1);
        check("async rst out", {24'd0, out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("post rst push out_valid", {31'd0, out_valid}, 32'd1);
        check("post rst push out", {24'd0, out}, 32'h77);
        check("post rst out2_valid", {31'd0, out2_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold%0d out", k), {24'd0, out}, 32'h77);
            check($sformatf("hold%0d out2_valid", k), {31'd0, out2_valid}, 32'd0);
        end

`ifdef DEMUX_BUFFER_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("stats rst cnt1", {24'd0, cnt1}, 32'd0);
        check("stats rst cnt2", {24'd0, cnt2}, 32'd0);
        rst_n = 1'b1;
        for (int p = 0; p < 257; p++) begin
            @(negedge clk);
            drive(p[7:0], 1'b0, 1'b1, 1'b1, 1'b0);
        end
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("stats cnt1 wrap", {24'd0, cnt1}, 32'd1);
        check("stats cnt2", {24'd0, cnt2}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
